// File: rtl/avalon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pkg
// Brief    : Shared types for the Avalon-MM initiator and its helpers.
// Revision : 1.0 - initial release
// ============================================================================
package avalon_pkg;

   localparam int AV_ADDR_WIDTH = 2;
   localparam int AV_DATA_WIDTH = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } initiatorState_t;

   typedef struct packed {
      logic                     write;
      logic [AV_ADDR_WIDTH-1:0] address;
      logic [AV_DATA_WIDTH-1:0] data;
   } avalonCmd_t;

endpackage
`default_nettype wire

// File: rtl/avalon_pending_counter.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pending_counter
// Brief    : Saturating count of reads issued on the bus but not yet returned.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_pending_counter #(
   parameter int MAX_PENDING = 4,
   parameter int CNT_WIDTH   = $clog2(MAX_PENDING + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 dec,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 full,
   output logic                 empty
);

   localparam logic [CNT_WIDTH-1:0] C_MAX = CNT_WIDTH'(MAX_PENDING);

   logic [CNT_WIDTH-1:0] r_count;

   // Simultaneous inc and dec cancel; the count neither wraps nor underflows.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (inc && !dec && (r_count != C_MAX)) begin
         r_count <= r_count + 1'b1;
      end else if (dec && !inc && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign count = r_count;
   assign full  = (r_count == C_MAX);
   assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/avalon_initiator.sv
`default_nettype none
// ============================================================================
// Module   : avalon_initiator
// Brief    : Avalon-MM host: single-beat commands in, pipelined in-order reads.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_initiator
   import avalon_pkg::*;
#(
   parameter int ADDR_WIDTH  = AV_ADDR_WIDTH,
   parameter int DATA_WIDTH  = AV_DATA_WIDTH,
   parameter int MAX_PENDING = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmdValid,
   output logic                  cmdReady,
   input  logic                  cmdWrite,
   input  logic [ADDR_WIDTH-1:0] cmdAddress,
   input  logic [DATA_WIDTH-1:0] cmdData,
   output logic                  rspValid,
   output logic [DATA_WIDTH-1:0] rspData,
   output logic                  busy,
   output logic                  protocolError,
   output logic                  avRead,
   output logic                  avWrite,
   output logic [ADDR_WIDTH-1:0] avAddress,
   output logic [DATA_WIDTH-1:0] avWriteData,
   input  logic                  avWaitRequest,
   input  logic                  avReadDataValid,
   input  logic [DATA_WIDTH-1:0] avReadData
);

   localparam int                   CNT_WIDTH = $clog2(MAX_PENDING + 1);
   localparam logic [CNT_WIDTH-1:0] C_MAX_M1  = CNT_WIDTH'(MAX_PENDING - 1);

   initiatorState_t       r_state;
   initiatorState_t       w_stateNext;
   avalonCmd_t            r_cmd;
   logic                  r_rspValid;
   logic [DATA_WIDTH-1:0] r_rspData;
   logic                  r_protocolError;

   logic                  w_issueDone;
   logic                  w_readDone;
   logic                  w_room;
   logic                  w_cmdReady;
   logic                  w_accept;
   logic [CNT_WIDTH-1:0]  w_count;
   logic                  w_full;
   logic                  w_empty;

   avalon_pending_counter #(
      .MAX_PENDING (MAX_PENDING),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_pending (
      .clk   (clk),
      .reset (reset),
      .inc   (w_readDone),
      .dec   (avReadDataValid),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A read completing this cycle already occupies a pending slot for the new command.
   always_comb begin
      w_stateNext = r_state;
      w_issueDone = (r_state == ISSUE) && !avWaitRequest;
      w_readDone  = w_issueDone && !r_cmd.write;
      w_room      = w_readDone ? (w_count < C_MAX_M1) : !w_full;
      w_cmdReady  = reset && ((r_state == IDLE) || w_issueDone) && w_room;
      w_accept    = cmdValid && w_cmdReady;
      avRead      = (r_state == ISSUE) && !r_cmd.write;
      avWrite     = (r_state == ISSUE) && r_cmd.write;
      case (r_state)
         IDLE:    if (w_accept) w_stateNext = ISSUE;
         ISSUE:   if (w_issueDone) w_stateNext = w_accept ? ISSUE : IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmd <= '0;
      end else if (w_accept) begin
         r_cmd.write   <= cmdWrite;
         r_cmd.address <= cmdAddress;
         r_cmd.data    <= cmdData;
      end
   end

   // Data arriving with nothing outstanding is dropped and flagged until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rspValid      <= 1'b0;
         r_rspData       <= '0;
         r_protocolError <= 1'b0;
      end else begin
         r_rspValid <= avReadDataValid && !w_empty;
         if (avReadDataValid && !w_empty) begin
            r_rspData <= avReadData;
         end
         if (avReadDataValid && w_empty) begin
            r_protocolError <= 1'b1;
         end
      end
   end

   assign cmdReady      = w_cmdReady;
   assign avAddress     = r_cmd.address;
   assign avWriteData   = r_cmd.data;
   assign rspValid      = r_rspValid;
   assign rspData       = r_rspData;
   assign protocolError = r_protocolError;
   assign busy          = (r_state == ISSUE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_avalon_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_initiator
// Brief    : Scoreboard bench with an Avalon responder model (wait + latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_initiator;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmdValid = 1'b0;
   logic        cmdReady;
   logic        cmdWrite = 1'b0;
   logic [1:0]  cmdAddress = '0;
   logic [31:0] cmdData = '0;
   logic        rspValid;
   logic [31:0] rspData;
   logic        busy;
   logic        protocolError;
   logic        avRead;
   logic        avWrite;
   logic [1:0]  avAddress;
   logic [31:0] avWriteData;
   logic        avWaitRequest;
   logic        avReadDataValid;
   logic [31:0] avReadData;

   avalon_initiator #(
      .ADDR_WIDTH  (2),
      .DATA_WIDTH  (32),
      .MAX_PENDING (4)
   ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .cmdValid        (cmdValid),
      .cmdReady        (cmdReady),
      .cmdWrite        (cmdWrite),
      .cmdAddress      (cmdAddress),
      .cmdData         (cmdData),
      .rspValid        (rspValid),
      .rspData         (rspData),
      .busy            (busy),
      .protocolError   (protocolError),
      .avRead          (avRead),
      .avWrite         (avWrite),
      .avAddress       (avAddress),
      .avWriteData     (avWriteData),
      .avWaitRequest   (avWaitRequest),
      .avReadDataValid (avReadDataValid),
      .avReadData      (avReadData)
   );

   always #5 clk = ~clk;

   // ---------------- responder model ----------------
   typedef struct {
      int          due;
      logic [31:0] data;
   } rd_t;

   int          wait_cfg = 0;
   int          lat_cfg  = 1;
   int          inj_req  = 0;
   int          inj_ack  = 0;
   int          wcnt     = 0;
   int          cyc      = 0;
   logic [31:0] mem [4];
   rd_t         rdq[$];

   initial begin
      mem[0] = 32'hDEADBEEF;
      mem[1] = 32'h11111111;
      mem[2] = 32'h22222222;
      mem[3] = 32'h33333333;
   end

   assign avWaitRequest = (avRead || avWrite) && (wcnt < wait_cfg);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         wcnt            <= 0;
         avReadDataValid <= 1'b0;
         avReadData      <= '0;
         rdq.delete();
      end else begin
         avReadDataValid <= 1'b0;
         if (avRead || avWrite) begin
            if (avWaitRequest) begin
               wcnt <= wcnt + 1;
            end else begin
               wcnt <= 0;
               if (avWrite) mem[avAddress] <= avWriteData;
               else         rdq.push_back('{cyc + lat_cfg - 1, mem[avAddress]});
            end
         end
         if (rdq.size() > 0 && rdq[0].due <= cyc) begin
            avReadDataValid <= 1'b1;
            avReadData      <= rdq[0].data;
            rdq.pop_front();
         end else if (inj_req != inj_ack) begin
            avReadDataValid <= 1'b1;
            avReadData      <= 32'h00000BAD;
            inj_ack         <= inj_ack + 1;
         end
         cyc = cyc + 1;
      end
   end

   // ---------------- scoreboard + stimulus ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Call just after a negedge; returns at the negedge following acceptance.
   task automatic issue(input bit w, input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
      int t = 0;
      cmdValid = 1'b1; cmdWrite = w; cmdAddress = a; cmdData = d;
      #1;
      while (!cmdReady && t < 200) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 200) chk("cmd_accept_timeout", 32'd0, 32'd1);
      if (!w) exp_q.push_back(exp);
      @(negedge clk);
      cmdValid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk); t++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      bit saw_stall;
      int maxcnt;

      fork
         forever begin
            @(negedge clk);
            if (reset && rspValid) begin
               if (exp_q.size() == 0) chk("unexpected_rsp", rspData, 32'hFFFFFFFF);
               else                   chk("rsp_data", rspData, exp_q.pop_front());
            end
         end
      join_none

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_cmdReady", {31'd0, cmdReady}, 32'd0);
      chk("rst_strobes",  {30'd0, avRead, avWrite}, 32'd0);
      chk("rst_busy_err", {30'd0, busy, protocolError}, 32'd0);
      chk("rst_rspValid", {31'd0, rspValid}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_cmdReady", {31'd0, cmdReady}, 32'd1);

      // 1: zero-wait write, strobe exactly one cycle
      wait_cfg = 0; lat_cfg = 1;
      issue(1'b1, 2'd1, 32'h5, 32'h0);
      chk("t1_avWrite", {31'd0, avWrite}, 32'd1);
      chk("t1_addr", {30'd0, avAddress}, 32'd1);
      chk("t1_data", avWriteData, 32'h5);
      @(negedge clk);
      chk("t1_strobe_off", {31'd0, avWrite}, 32'd0);

      // 2: single read, latency 1
      issue(1'b0, 2'd0, 32'h0, 32'hDEADBEEF);
      chk("t2_avRead", {31'd0, avRead}, 32'd1);
      drain("t2_drain");
      @(negedge clk);
      chk("t2_busy", {31'd0, busy}, 32'd0);

      // 3: write held by 3 wait cycles
      wait_cfg = 3;
      issue(1'b1, 2'd2, 32'h0000A5A5, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("t3_avWrite", {31'd0, avWrite}, 32'd1);
         chk("t3_addr", {30'd0, avAddress}, 32'd2);
         chk("t3_data", avWriteData, 32'h0000A5A5);
         chk("t3_cmdReady", {31'd0, cmdReady}, (i < 3) ? 32'd0 : 32'd1);
         @(negedge clk);
      end
      chk("t3_strobe_off", {31'd0, avWrite}, 32'd0);
      wait_cfg = 0;

      // 4: six back-to-back reads, latency 5, pending limit 4
      lat_cfg = 5; saw_stall = 1'b0; maxcnt = 0;
      fork
         begin
            issue(1'b0, 2'd0, 32'h0, 32'hDEADBEEF);
            issue(1'b0, 2'd1, 32'h0, 32'h00000005);
            issue(1'b0, 2'd2, 32'h0, 32'h0000A5A5);
            issue(1'b0, 2'd3, 32'h0, 32'h33333333);
            issue(1'b0, 2'd0, 32'h0, 32'hDEADBEEF);
            issue(1'b0, 2'd1, 32'h0, 32'h00000005);
         end
         begin
            for (int i = 0; i < 30; i++) begin
               @(negedge clk); #2;
               if (int'(u_dut.u_pending.count) > maxcnt) maxcnt = int'(u_dut.u_pending.count);
               if (!cmdReady && u_dut.u_pending.count == 3'd4) saw_stall = 1'b1;
            end
         end
      join
      drain("t4_drain");
      chk("t4_stall_at_4", {31'd0, saw_stall}, 32'd1);
      chk("t4_max_pending", 32'(maxcnt), 32'd4);
      @(negedge clk);
      chk("t4_busy", {31'd0, busy}, 32'd0);

      // 5: completion and data return in the same cycle, then a stray beat
      lat_cfg = 1;
      issue(1'b0, 2'd3, 32'h0, 32'h33333333);
      issue(1'b0, 2'd0, 32'h0, 32'hDEADBEEF);
      @(negedge clk);
      chk("t5_pending_same", {29'd0, u_dut.u_pending.count}, 32'd1);
      @(negedge clk);
      chk("t5_pending_zero", {29'd0, u_dut.u_pending.count}, 32'd0);
      drain("t5_drain");
      repeat (2) @(negedge clk);
      chk("t5_err_before", {31'd0, protocolError}, 32'd0);
      inj_req = inj_req + 1;
      repeat (3) @(negedge clk);
      chk("t5_protocolError", {31'd0, protocolError}, 32'd1);
      chk("t5_pending_stray", {29'd0, u_dut.u_pending.count}, 32'd0);

      // 6: reset during a stalled transfer
      wait_cfg = 100;
      issue(1'b1, 2'd0, 32'h77, 32'h0);
      @(negedge clk);
      chk("t6_held", {31'd0, avWrite}, 32'd1);
      #2 reset = 1'b0;
      @(posedge clk); #1;
      chk("t6_strobes", {30'd0, avRead, avWrite}, 32'd0);
      chk("t6_addr_data", {30'd0, avAddress} | avWriteData, 32'd0);
      chk("t6_cmdReady", {31'd0, cmdReady}, 32'd0);
      chk("t6_rsp", {31'd0, rspValid} | rspData, 32'd0);
      chk("t6_busy_err", {30'd0, busy, protocolError}, 32'd0);
      @(negedge clk);
      reset = 1'b1; wait_cfg = 0;
      @(negedge clk);
      chk("t6_busy_after", {31'd0, busy}, 32'd0);
      chk("t6_pending_after", {29'd0, u_dut.u_pending.count}, 32'd0);
      chk("t6_cmdReady_after", {31'd0, cmdReady}, 32'd1);
      issue(1'b0, 2'd1, 32'h0, 32'h00000005);
      drain("t6_read_after");

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
